// File: rtl/three_way_toom_cook_ds.sv
// Digit-serial GF(2)[x] multiplier, 3-way limb split, D a-bits per cycle per sub-product.
// Optional macro TC3_OUT_REG_EN adds one register stage after the 5-way XOR combine.
module three_way_toom_cook_ds #(
  parameter int N = 409,
  parameter int D = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);

  // state | meaning
  // IDLE  | waiting for start
  // MUL   | ITER cycles of partial-product accumulation
  // COMB  | combine sub-products into c
  // OUTR  | extra output stage (TC3_OUT_REG_EN only)

  localparam int K    = (N + 2) / 3;
  localparam int ITER = (K + D - 1) / D;
  localparam int CW   = $clog2(ITER + 1);
  localparam int PW   = 2 * K - 1;
  localparam int PADW = 3 * K;
  localparam int OW   = 2 * N;

  typedef enum logic [1:0] {IDLE, MUL, COMB, OUTR} state_t;

  state_t          state;
  logic [K-1:0]    a_sh    [3];
  logic [PW-1:0]   b_sh    [3];
  logic [PW-1:0]   acc     [3][3];
  logic [PW-1:0]   acc_nxt [3][3];
  logic [CW-1:0]   cnt;
  logic [PADW-1:0] a_pad;
  logic [PADW-1:0] b_pad;
  logic [OW-1:0]   comb_res;
`ifdef TC3_OUT_REG_EN
  logic [OW-1:0]   res_q;
`endif

  assign a_pad = PADW'(a);
  assign b_pad = PADW'(b);

  // a limbs shift right and b limbs shift left each cycle, so bit j of a_sh is a_x[cnt*D+j]
  always_comb begin
    for (int x = 0; x < 3; x++) begin
      for (int y = 0; y < 3; y++) begin
        acc_nxt[x][y] = acc[x][y];
        for (int j = 0; j < D; j++) begin
          if (a_sh[x][j]) acc_nxt[x][y] = acc_nxt[x][y] ^ (b_sh[y] << j);
        end
      end
    end
  end

  // bits shifted beyond 2N are zero by construction
  always_comb begin
    comb_res = OW'(acc[0][0])
             ^ (OW'(acc[0][1] ^ acc[1][0]) << K)
             ^ (OW'(acc[0][2] ^ acc[1][1] ^ acc[2][0]) << (2 * K))
             ^ (OW'(acc[1][2] ^ acc[2][1]) << (3 * K))
             ^ (OW'(acc[2][2]) << (4 * K));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      c     <= '0;
      cnt   <= '0;
      for (int x = 0; x < 3; x++) begin
        a_sh[x] <= '0;
        b_sh[x] <= '0;
        for (int y = 0; y < 3; y++) acc[x][y] <= '0;
      end
`ifdef TC3_OUT_REG_EN
      res_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh[0] <= a_pad[K-1:0];
            a_sh[1] <= a_pad[2*K-1:K];
            a_sh[2] <= a_pad[3*K-1:2*K];
            b_sh[0] <= PW'(b_pad[K-1:0]);
            b_sh[1] <= PW'(b_pad[2*K-1:K]);
            b_sh[2] <= PW'(b_pad[3*K-1:2*K]);
            for (int x = 0; x < 3; x++)
              for (int y = 0; y < 3; y++) acc[x][y] <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          acc <= acc_nxt;
          for (int x = 0; x < 3; x++) begin
            a_sh[x] <= a_sh[x] >> D;
            b_sh[x] <= b_sh[x] << D;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= COMB;
        end
        COMB: begin
`ifdef TC3_OUT_REG_EN
          res_q <= comb_res;
          state <= OUTR;
`else
          c     <= comb_res;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
`ifdef TC3_OUT_REG_EN
        OUTR: begin
          c     <= res_q;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_three_way_toom_cook_ds.sv
// Directed bench for three_way_toom_cook_ds at N=409, D=1: products, latency, handshake, reset abort.
module tb_three_way_toom_cook_ds;
  localparam int N    = 409;
  localparam int D    = 1;
  localparam int W    = 2 * N;
  localparam int ITER = ((N + 2) / 3 + D - 1) / D;
`ifdef TC3_OUT_REG_EN
  localparam int LAT = ITER + 2;
`else
  localparam int LAT = ITER + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] c;

  int n_checks = 0;
  int n_pass   = 0;

  three_way_toom_cook_ds #(.N(N), .D(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .c(c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic launch(input logic [N-1:0] ta, input logic [N-1:0] tbv);
    @(negedge clk);
    a = ta;
    b = tbv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // counts edges after the accepting edge until done is seen (bounded)
  task automatic wait_done(input int base, output int lat);
    lat = base;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!done && lat < 4 * ITER);
  endtask

  task automatic count_dones(input int cycles, output int nd);
    nd = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tbv,
                         input logic [W-1:0] exp);
    int lat;
    launch(ta, tbv);
    check({tag, " busy"}, W'(busy), W'(1));
    wait_done(0, lat);
    check({tag, " latency"}, W'(lat), W'(LAT));
    check({tag, " c"}, c, exp);
    @(posedge clk);
    #1 check({tag, " done_pulse"}, W'(done), W'(0));
  endtask

  initial begin
    logic [N-1:0] one_n, ones_n;
    logic [W-1:0] one_w, exp;
    int lat, nd;
    one_n  = 1;
    ones_n = '1;
    one_w  = 1;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset c", c, W'(0));
    rst = 1'b0;

    run_vec("one_x_one", one_n, one_n, one_w);
    run_vec("three_sq", N'(3), N'(3), W'(5));
    run_vec("top_bit_sq", one_n << 408, one_n << 408, one_w << 816);
    run_vec("x2x1_x1", N'(7), N'(3), W'(9));
    run_vec("limb_cross", one_n << 137, one_n << 274, one_w << 411);
    run_vec("ones_x1", ones_n, N'(3), (one_w << 409) | one_w);
    exp = (one_w << 500) | (one_w << 205) | (one_w << 300) | (one_w << 5);
    run_vec("sparse", (one_n << 200) | one_n, (one_n << 300) | (one_n << 5), exp);
    run_vec("zero", '0, ones_n, '0);

    // start while busy is ignored
    launch(N'(7), N'(3));
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = N'(5); b = N'(5); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(5, lat);
    check("busy_start latency", W'(lat), W'(LAT));
    check("busy_start c", c, W'(9));
    count_dones(ITER + 5, nd);
    check("busy_start no_queue", W'(nd), W'(0));

    // reset mid-MUL aborts the operation
    launch(N'(3), N'(3));
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort busy", W'(busy), W'(0));
    check("abort done", W'(done), W'(0));
    check("abort c", c, W'(0));
    count_dones(ITER + 5, nd);
    check("abort no_done", W'(nd), W'(0));
    run_vec("post_abort", N'(3), N'(3), W'(5));

    // start held high across done; inputs changed after acceptance
    @(negedge clk);
    a = one_n << 137; b = one_n << 274; start = 1'b1;
    @(posedge clk);
    #1 a = N'(3); b = N'(3);
    wait_done(0, lat);
    check("b2b first latency", W'(lat), W'(LAT));
    check("b2b first c", c, one_w << 411);
    a = N'(7); b = N'(3);
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b second busy", W'(busy), W'(1));
    wait_done(0, lat);
    check("b2b second latency", W'(lat), W'(LAT));
    check("b2b second c", c, W'(9));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
